// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forward-select encodings
// and the default register-index width.
`timescale 1ns/1ps
package hazard_pkg;

  localparam int HAZ_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MUL   = 2'b11;

endpackage

// File: rtl/hazard_scoreboard_unit_mul.sv
// Single-entry scoreboard for the fixed-latency side multiplier: tracks the
// in-flight destination and counts down to the write-back cycle.
`timescale 1ns/1ps
module mul_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = HAZ_AW,
  parameter int MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic [AW-1:0] issue_rd,
  output logic          busy,
  output logic          cnt_le1,
  output logic          done,
  output logic [AW-1:0] rd
);

  localparam int            CW       = $clog2(MUL_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

  logic [CW-1:0] cnt;

  // A new issue on the done edge wins over retiring the old multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rd   <= '0;
    end else if (issue) begin
      busy <= 1'b1;
      cnt  <= CNT_INIT;
      rd   <= issue_rd;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done    = busy & (cnt == '0);
  assign cnt_le1 = (cnt <= CW'(1));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit: operand-forward selection, load-use and multiplier stalls,
// and the registered per-source forward selects driving the EX operand muxes.
`timescale 1ns/1ps
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int AW      = HAZ_AW,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_use,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_regwrite,
  input  logic               id_is_mul,
  input  logic               flush,
  input  logic [AW-1:0]      ex_rd,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic [AW-1:0]      mem_rd,
  input  logic               mem_regwrite,
  output logic               stall,
  output logic [2*NSRC-1:0]  ex_fwd_sel,
  output logic               mul_busy,
  output logic               mul_done,
  output logic [AW-1:0]      mul_rd_o
);

  logic          busy;
  logic          cnt_le1;
  logic          done;
  logic [AW-1:0] mul_rd;
  logic          mul_issue;

  logic [NSRC-1:0]   hit_ex;
  logic [NSRC-1:0]   hit_mem;
  logic [NSRC-1:0]   hit_mul;
  logic [2*NSRC-1:0] sel_next;

  logic cnt_gt0;
  logic cnt_gt1;
  logic cnt_eq1;

  assign cnt_gt0 = busy & ~done;
  assign cnt_gt1 = busy & ~cnt_le1;
  assign cnt_eq1 = busy & cnt_le1 & ~done;

  // Register 0 and unread sources never match any producer.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    logic [AW-1:0] src;
    logic          used;

    assign src        = id_src[g*AW +: AW];
    assign used       = id_src_use[g] & (src != '0);
    assign hit_ex[g]  = used & (src == ex_rd);
    assign hit_mem[g] = used & (src == mem_rd);
    assign hit_mul[g] = used & (src == mul_rd);

    assign sel_next[g*2 +: 2] =
        (hit_ex[g] & ex_regwrite & ~ex_memread) ? FWD_EXMEM :
        (hit_mem[g] & mem_regwrite)             ? FWD_MEMWB :
        (hit_mul[g] & cnt_eq1)                  ? FWD_MUL   :
                                                  FWD_RF;
  end

  logic load_use;
  logic mul_raw;
  logic mul_struct;
  logic waw_alu;
  logic waw_mul;
  logic advance;

  assign load_use   = ex_memread & ex_regwrite & (|hit_ex);
  assign mul_raw    = cnt_gt1 & (|hit_mul);
  assign mul_struct = id_is_mul & cnt_gt0;
  assign waw_alu    = id_regwrite & cnt_gt0 & (id_rd == mul_rd);
  assign waw_mul    = id_is_mul & (id_rd != '0) &
                      ((ex_regwrite & (id_rd == ex_rd)) |
                       (mem_regwrite & (id_rd == mem_rd)));

  assign stall     = id_valid & ~flush &
                     (load_use | mul_raw | mul_struct | waw_alu | waw_mul);
  assign advance   = id_valid & ~flush & ~stall;
  assign mul_issue = advance & id_is_mul;

  // Anything that does not advance enters EX as a bubble with all-regfile selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_fwd_sel <= '0;
    end else begin
      ex_fwd_sel <= advance ? sel_next : '0;
    end
  end

  mul_scoreboard #(
    .AW      (AW),
    .MUL_LAT (MUL_LAT)
  ) u_mul_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (mul_issue),
    .issue_rd (id_rd),
    .busy     (busy),
    .cnt_le1  (cnt_le1),
    .done     (done),
    .rd       (mul_rd)
  );

  assign mul_busy = busy;
  assign mul_done = done;
  assign mul_rd_o = mul_rd;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic
// against a cycle-count model of the multiplier and the hazard rules.
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0]   id_src_use;
  logic [AW-1:0]     id_rd;
  logic              id_regwrite;
  logic              id_is_mul;
  logic              flush;
  logic [AW-1:0]     ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [AW-1:0]     mem_rd;
  logic              mem_regwrite;
  logic              stall;
  logic [2*NSRC-1:0] ex_fwd_sel;
  logic              mul_busy;
  logic              mul_done;
  logic [AW-1:0]     mul_rd_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard_unit #(
    .AW      (AW),
    .NSRC    (NSRC),
    .MUL_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_use   (id_src_use),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_is_mul    (id_is_mul),
    .flush        (flush),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .stall        (stall),
    .ex_fwd_sel   (ex_fwd_sel),
    .mul_busy     (mul_busy),
    .mul_done     (mul_done),
    .mul_rd_o     (mul_rd_o)
  );

  always #5 clk = ~clk;

  // Model: the multiply is described by its issue cycle; everything else
  // follows from how many cycles remain until its result is ready.
  int          now;
  bit          m_have;
  int          m_issue;
  logic [4:0]  m_rd;
  logic [3:0]  m_fwd;
  bit          e_stall;
  logic [3:0]  e_next;
  bit          e_issue;
  bit          e_busy;
  bit          e_done;

  task automatic model_reset();
    now    = 0;
    m_have = 0;
    m_issue = 0;
    m_rd   = '0;
    m_fwd  = '0;
  endtask

  task automatic model_eval();
    int         rem;
    bit         hit_ld;
    bit         hit_mul;
    bit         used;
    logic [4:0] s;
    logic [1:0] sel;
    rem    = m_have ? (m_issue + LAT - now) : -1;
    e_busy = (rem >= 0);
    e_done = (rem == 0);
    hit_ld = 0;
    hit_mul = 0;
    e_next = '0;
    for (int i = 0; i < NSRC; i++) begin
      s    = id_src[i*AW +: AW];
      used = id_src_use[i] && (s != 0);
      if (used && s == ex_rd) hit_ld = 1;
      if (used && e_busy && rem > 1 && s == m_rd) hit_mul = 1;
      if (used && ex_regwrite && !ex_memread && s == ex_rd) sel = 2'b10;
      else if (used && mem_regwrite && s == mem_rd) sel = 2'b01;
      else if (used && e_busy && rem == 1 && s == m_rd) sel = 2'b11;
      else sel = 2'b00;
      e_next[i*2 +: 2] = sel;
    end
    e_stall = id_valid && !flush && (
                (ex_memread && ex_regwrite && hit_ld) ||
                hit_mul ||
                (id_is_mul && e_busy && rem > 0) ||
                (id_regwrite && e_busy && rem > 0 && id_rd == m_rd) ||
                (id_is_mul && id_rd != 0 &&
                 ((ex_regwrite && id_rd == ex_rd) || (mem_regwrite && id_rd == mem_rd))));
    e_issue = id_valid && !flush && !e_stall && id_is_mul;
    if (!(id_valid && !flush && !e_stall)) e_next = '0;
  endtask

  task automatic step_cycle();
    model_eval();
    @(posedge clk);
    if (e_issue) begin
      m_have  = 1;
      m_issue = now;
      m_rd    = id_rd;
    end
    m_fwd = e_next;
    now++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_valid     = 0;
    id_src       = '0;
    id_src_use   = '0;
    id_rd        = '0;
    id_regwrite  = 0;
    id_is_mul    = 0;
    flush        = 0;
    ex_rd        = '0;
    ex_regwrite  = 0;
    ex_memread   = 0;
    mem_rd       = '0;
    mem_regwrite = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 0;
    #1;
    n_tests++;
    if (stall !== 1'b0 || mul_busy !== 1'b0 || mul_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: stall/busy/done=%b%b%b want 000", stall, mul_busy, mul_done);
    end
    n_tests++;
    if (ex_fwd_sel !== 4'b0000 || mul_rd_o !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: fwd=%b rd=%0d want 0000/0", ex_fwd_sel, mul_rd_o);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_forwarding();
    do_reset();
    id_valid = 1; id_src = 10'd5; id_src_use = 2'b01; ex_rd = 5; ex_regwrite = 1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL alu_ex_stall: got %b want 0", stall);
    end
    step_cycle();
    clear_inputs();
    id_valid = 1; id_src = 10'd5; id_src_use = 2'b01; mem_rd = 5; mem_regwrite = 1;
    #1;
    n_tests++;
    if (ex_fwd_sel !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL fwd_exmem: got %b want 0010", ex_fwd_sel);
    end
    step_cycle();
    clear_inputs();
    id_valid = 1; id_src = {5'd6, 5'd0}; id_src_use = 2'b10; ex_rd = 6; ex_regwrite = 1;
    #1;
    n_tests++;
    if (ex_fwd_sel !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL fwd_memwb: got %b want 0001", ex_fwd_sel);
    end
    step_cycle();
    clear_inputs();
    #1;
    n_tests++;
    if (ex_fwd_sel !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL fwd_src1_exmem: got %b want 1000", ex_fwd_sel);
    end
    step_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1; id_src = 10'd7; id_src_use = 2'b01;
    ex_rd = 7; ex_regwrite = 1; ex_memread = 1;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL load_use_stall: got %b want 1", stall);
    end
    step_cycle();
    clear_inputs();
    id_valid = 1; id_src = 10'd7; id_src_use = 2'b01; mem_rd = 7; mem_regwrite = 1;
    #1;
    n_tests++;
    if (stall !== 1'b0 || ex_fwd_sel !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL load_use_bubble: stall=%b fwd=%b want 0/0000", stall, ex_fwd_sel);
    end
    step_cycle();
    clear_inputs();
    #1;
    n_tests++;
    if (ex_fwd_sel !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL load_use_fwd: got %b want 0001", ex_fwd_sel);
    end
    step_cycle();
  endtask

  task automatic test_mul_timing();
    do_reset();
    id_valid = 1; id_is_mul = 1; id_regwrite = 1; id_rd = 9;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mul_issue_stall: got %b want 0", stall);
    end
    step_cycle();
    clear_inputs();
    id_valid = 1; id_src = 10'd9; id_src_use = 2'b01; id_regwrite = 1; id_rd = 4;
    #1;
    n_tests++;
    if (stall !== 1'b1 || mul_busy !== 1'b1 || mul_done !== 1'b0 || mul_rd_o !== 5'd9) begin
      n_fail++;
      $display("[TB] FAIL mul_t1: stall/busy/done=%b%b%b rd=%0d want 110/9", stall, mul_busy, mul_done, mul_rd_o);
    end
    step_cycle();
    #1;
    n_tests++;
    if (stall !== 1'b0 || mul_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mul_t2: stall/done=%b%b want 00", stall, mul_done);
    end
    step_cycle();
    clear_inputs();
    #1;
    n_tests++;
    if (ex_fwd_sel !== 4'b0011 || mul_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mul_t3: fwd=%b done=%b want 0011/1", ex_fwd_sel, mul_done);
    end
    step_cycle();
    #1;
    n_tests++;
    if (mul_done !== 1'b0 || mul_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mul_t4: done/busy=%b%b want 00", mul_done, mul_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_stall;
    do_reset();
    id_valid = 1; id_is_mul = 1; id_regwrite = 1; id_rd = 9;
    step_cycle();
    want_stall = 4'b0110;
    for (int t = 1; t <= 3; t++) begin
      clear_inputs();
      id_valid = 1; id_is_mul = 1; id_regwrite = 1; id_rd = 10;
      #1;
      n_tests++;
      if (stall !== want_stall[t] || mul_done !== (t == 3)) begin
        n_fail++;
        $display("[TB] FAIL b2b_t%0d: stall=%b done=%b want %b/%b", t, stall, mul_done, want_stall[t], (t == 3));
      end
      step_cycle();
    end
    clear_inputs();
    #1;
    n_tests++;
    if (mul_busy !== 1'b1 || mul_done !== 1'b0 || mul_rd_o !== 5'd10) begin
      n_fail++;
      $display("[TB] FAIL b2b_t4: busy/done=%b%b rd=%0d want 10/10", mul_busy, mul_done, mul_rd_o);
    end
    step_cycle();
    step_cycle();
    #1;
    n_tests++;
    if (mul_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_t6_done: got %b want 1", mul_done);
    end
    step_cycle();
    #1;
    n_tests++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_t7_idle: busy/done=%b%b want 00", mul_busy, mul_done);
    end
  endtask

  task automatic test_reg0_unused();
    do_reset();
    id_valid = 1; id_src = 10'd0; id_src_use = 2'b01;
    ex_rd = 0; ex_regwrite = 1; ex_memread = 1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reg0_stall: got %b want 0", stall);
    end
    step_cycle();
    clear_inputs();
    id_valid = 1; id_src = 10'd7; id_src_use = 2'b00;
    ex_rd = 7; ex_regwrite = 1; ex_memread = 1;
    #1;
    n_tests++;
    if (stall !== 1'b0 || ex_fwd_sel !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL unused_src: stall=%b fwd=%b want 0/0000", stall, ex_fwd_sel);
    end
    step_cycle();
    clear_inputs();
    id_valid = 1; flush = 1; id_is_mul = 1; id_rd = 3;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_stall: got %b want 0", stall);
    end
    step_cycle();
    clear_inputs();
    #1;
    n_tests++;
    if (mul_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_no_issue: busy=%b want 0", mul_busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    int done_seen;
    do_reset();
    id_valid = 1; id_is_mul = 1; id_regwrite = 1; id_rd = 9;
    step_cycle();
    clear_inputs();
    id_valid = 1; id_src = 10'd5; id_src_use = 2'b01; ex_rd = 5; ex_regwrite = 1;
    step_cycle();
    clear_inputs();
    rst_n = 0;
    #1;
    n_tests++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0 || ex_fwd_sel !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_mul: busy/done=%b%b fwd=%b want 00/0000", mul_busy, mul_done, ex_fwd_sel);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (mul_done === 1'b1) done_seen++;
      step_cycle();
    end
    n_tests++;
    if (done_seen != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_done: saw %0d done cycles want 0", done_seen);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_valid     = ($urandom_range(0, 7) != 0);
      id_src       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_src_use   = 2'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 7));
      id_regwrite  = 1'($urandom_range(0, 1));
      id_is_mul    = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = ($urandom_range(0, 3) == 0);
      mem_rd       = 5'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom_range(0, 1));
      #1;
      model_eval();
      n_tests++;
      if (stall !== e_stall) begin
        n_fail++;
        $display("[TB] FAIL rand_stall c=%0d: got %b want %b", c, stall, e_stall);
      end
      n_tests++;
      if (ex_fwd_sel !== m_fwd) begin
        n_fail++;
        $display("[TB] FAIL rand_fwd c=%0d: got %b want %b", c, ex_fwd_sel, m_fwd);
      end
      n_tests++;
      if (mul_busy !== e_busy || mul_done !== e_done) begin
        n_fail++;
        $display("[TB] FAIL rand_mul c=%0d: busy/done=%b%b want %b%b", c, mul_busy, mul_done, e_busy, e_done);
      end
      if (e_busy) begin
        n_tests++;
        if (mul_rd_o !== m_rd) begin
          n_fail++;
          $display("[TB] FAIL rand_mul_rd c=%0d: got %0d want %0d", c, mul_rd_o, m_rd);
        end
      end
      step_cycle();
    end
  endtask

  initial begin
    rst_n = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul_timing();
    test_back_to_back();
    test_reg0_unused();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
